// File: rtl/parse_pkg.sv
// parse_pkg
//   Shared types and constants for the header parse sequencer:
//   sequencer state encoding, per-frame classification codes and the
//   protocol identifiers that steer the stage chain.
package parse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH,
        ST_IPV4,
        ST_L4,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        CLS_NON_IP   = 2'd0,
        CLS_OTHER_IP = 2'd1,
        CLS_UDP      = 2'd2,
        CLS_TCP      = 2'd3
    } res_class_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;

endpackage

// File: rtl/parse_sat_counter.sv
// parse_sat_counter
//   Statistics counter that increments by one per cycle of inc and holds
//   at all-ones instead of wrapping.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears count
//   inc    increment request
//   count  current count value
module parse_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parse_stage_ctrl.sv
// parse_stage_ctrl
//   Frame-level sequencer for the Ethernet -> IPv4 -> UDP/TCP header parse
//   chain. Watches the ingress beat handshake, enables one parser stage at a
//   time from the stages' done strobes, flushes stage state after each frame
//   and presents one classification result per frame on a valid/ready port.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_tvalid, s_tlast, s_tready   ingress handshake (monitored; s_tready driven)
//   eth_done, eth_type            Ethernet stage completion and ethertype
//   ipv4_done, ipv4_proto,
//   ipv4_err                      IPv4 stage completion, protocol, header error
//   l4_done                       UDP/TCP stage completion
//   eth_en, ipv4_en, l4_en        one-hot stage enables
//   stage_flush                   1-cycle pulse after every frame end
//   res_valid, res_ready,
//   res_class, res_err            per-frame result handshake and payload
//   cnt_frames, cnt_errs          saturating statistics counters
module parse_stage_ctrl
    import parse_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned STAGE_MAX_BEATS = 8,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    input  logic                 eth_done,
    input  logic [15:0]          eth_type,
    input  logic                 ipv4_done,
    input  logic [7:0]           ipv4_proto,
    input  logic                 ipv4_err,
    input  logic                 l4_done,
    output logic                 eth_en,
    output logic                 ipv4_en,
    output logic                 l4_en,
    output logic                 stage_flush,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_class,
    output logic                 res_err,
    output logic [CNT_WIDTH-1:0] cnt_frames,
    output logic [CNT_WIDTH-1:0] cnt_errs
);

    // No data path lives here; the width only has to describe whole bytes.
    if ((DATA_WIDTH % 8) != 0) begin : g_width_check
        $error("parse_stage_ctrl: DATA_WIDTH must be a multiple of 8");
    end

    localparam int unsigned CW = $clog2(STAGE_MAX_BEATS + 1);

    state_t         state_q, state_d;
    res_class_t     cls_q, cls_d, res_class_q;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           beat;
    logic           load;

    assign s_tready = !((state_q == ST_IDLE) && res_valid);
    assign beat     = s_tvalid && s_tready;

    assign eth_en    = (state_q == ST_ETH);
    assign ipv4_en   = (state_q == ST_IPV4);
    assign l4_en     = (state_q == ST_L4);
    assign res_class = res_class_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cls_q       <= CLS_NON_IP;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            res_valid   <= 1'b0;
            res_class_q <= CLS_NON_IP;
            res_err     <= 1'b0;
            stage_flush <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            stage_flush <= load;
            if (load) begin
                res_valid   <= 1'b1;
                res_class_q <= cls_d;
                res_err     <= err_d;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    cls_d = CLS_NON_IP;
                    err_d = 1'b0;
                    cnt_d = CW'(1);
                    if (s_tlast) begin
                        // Single-beat frame: Ethernet never got to finish.
                        err_d = 1'b1;
                        load  = 1'b1;
                    end else begin
                        state_d = ST_ETH;
                    end
                end
            end
            ST_ETH: begin
                if (eth_done) begin
                    cnt_d   = '0;
                    state_d = (eth_type == ETHERTYPE_IPV4) ? ST_IPV4 : ST_DRAIN;
                    cls_d   = (eth_type == ETHERTYPE_IPV4) ? CLS_OTHER_IP : CLS_NON_IP;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(STAGE_MAX_BEATS)) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_IPV4: begin
                if (ipv4_done) begin
                    cnt_d = '0;
                    if (ipv4_err) begin
                        state_d = ST_DRAIN;
                        cls_d   = CLS_OTHER_IP;
                        err_d   = 1'b1;
                    end else if (ipv4_proto == PROTO_UDP) begin
                        state_d = ST_L4;
                        cls_d   = CLS_UDP;
                    end else if (ipv4_proto == PROTO_TCP) begin
                        state_d = ST_L4;
                        cls_d   = CLS_TCP;
                    end else begin
                        state_d = ST_DRAIN;
                        cls_d   = CLS_OTHER_IP;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(STAGE_MAX_BEATS)) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_L4: begin
                if (l4_done) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(STAGE_MAX_BEATS)) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DRAIN: ;
            default: state_d = ST_IDLE;
        endcase

        // Frame end is resolved after the done decode above: only a frame that
        // already reached DRAIN is complete, anything else was truncated.
        if (beat && s_tlast && (state_q != ST_IDLE)) begin
            if (state_d != ST_DRAIN) begin
                err_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
            load    = 1'b1;
        end
    end

    parse_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_frames (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load),
        .count (cnt_frames)
    );

    parse_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_errs (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load && err_d),
        .count (cnt_errs)
    );

endmodule

// File: tb/tb_parse_stage_ctrl.sv
// tb_parse_stage_ctrl
//   Directed self-checking bench for parse_stage_ctrl.
module tb_parse_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tlast, s_tready;
    logic        eth_done, ipv4_done, ipv4_err, l4_done;
    logic [15:0] eth_type;
    logic [7:0]  ipv4_proto;
    logic        eth_en, ipv4_en, l4_en, stage_flush;
    logic        res_valid, res_ready, res_err;
    logic [1:0]  res_class;
    logic [31:0] cnt_frames, cnt_errs;

    int checks = 0;
    int fails  = 0;
    int flush_seen = 0;
    int ipv4_seen  = 0;

    parse_stage_ctrl #(
        .DATA_WIDTH      (64),
        .STAGE_MAX_BEATS (8),
        .CNT_WIDTH       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .eth_done    (eth_done),
        .eth_type    (eth_type),
        .ipv4_done   (ipv4_done),
        .ipv4_proto  (ipv4_proto),
        .ipv4_err    (ipv4_err),
        .l4_done     (l4_done),
        .eth_en      (eth_en),
        .ipv4_en     (ipv4_en),
        .l4_en       (l4_en),
        .stage_flush (stage_flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_err     (res_err),
        .cnt_frames  (cnt_frames),
        .cnt_errs    (cnt_errs)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stage_flush) flush_seen++;
        if (ipv4_en)     ipv4_seen++;
    end

    // Drive one cycle of inputs, advance past the edge, then drop the strobes.
    task automatic cyc(input logic v, input logic last, input logic ed, input logic [15:0] et,
                       input logic id, input logic [7:0] pr, input logic ie, input logic ld);
        s_tvalid = v; s_tlast = last; eth_done = ed; eth_type = et;
        ipv4_done = id; ipv4_proto = pr; ipv4_err = ie; l4_done = ld;
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; eth_done = 1'b0; ipv4_done = 1'b0;
        ipv4_err = 1'b0; l4_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; res_ready = 1'b0;
        s_tvalid = 0; s_tlast = 0; eth_done = 0; eth_type = '0;
        ipv4_done = 0; ipv4_proto = '0; ipv4_err = 0; l4_done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({eth_en, ipv4_en, l4_en, stage_flush, res_valid, res_err} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 000000", {eth_en, ipv4_en, l4_en, stage_flush, res_valid, res_err}); end
        checks++; if (s_tready !== 1'b1) begin
            fails++; $display("FAIL reset_tready: got %b expected 1", s_tready); end
        checks++; if (res_class !== 2'd0 || cnt_frames !== 32'd0 || cnt_errs !== 32'd0) begin
            fails++; $display("FAIL reset_cnt: class %0d frames %0d errs %0d expected 0 0 0", res_class, cnt_frames, cnt_errs); end
    endtask

    task automatic test_udp;
        int f0 = flush_seen;
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        checks++; if (eth_en !== 1'b1) begin fails++; $display("FAIL udp_eth_en: got %b expected 1", eth_en); end
        cyc(1, 0, 1, 16'h0800, 0, 8'd0, 0, 0);
        checks++; if ({eth_en, ipv4_en} !== 2'b01) begin fails++; $display("FAIL udp_ipv4_en: got %b expected 01", {eth_en, ipv4_en}); end
        cyc(1, 0, 0, 16'h0, 1, 8'd17, 0, 0);
        checks++; if ({ipv4_en, l4_en} !== 2'b01) begin fails++; $display("FAIL udp_l4_en: got %b expected 01", {ipv4_en, l4_en}); end
        cyc(1, 1, 0, 16'h0, 0, 8'd0, 0, 1);
        checks++; if ({res_valid, res_class, res_err} !== {1'b1, 2'd2, 1'b0}) begin
            fails++; $display("FAIL udp_result: got v%b c%0d e%b expected v1 c2 e0", res_valid, res_class, res_err); end
        checks++; if (cnt_frames !== 32'd1 || cnt_errs !== 32'd0) begin
            fails++; $display("FAIL udp_counters: got %0d/%0d expected 1/0", cnt_frames, cnt_errs); end
        checks++; if ({stage_flush, s_tready, l4_en} !== 3'b100) begin
            fails++; $display("FAIL udp_flush_idle: got %b expected 100", {stage_flush, s_tready, l4_en}); end
        res_ready = 1'b1;
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        res_ready = 1'b0;
        checks++; if ({res_valid, stage_flush, s_tready} !== 3'b001) begin
            fails++; $display("FAIL udp_accept: got %b expected 001", {res_valid, stage_flush, s_tready}); end
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        checks++; if (flush_seen - f0 !== 1) begin
            fails++; $display("FAIL udp_flush_count: got %0d expected 1", flush_seen - f0); end
    endtask

    task automatic test_arp;
        int i0 = ipv4_seen;
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        cyc(1, 1, 1, 16'h0806, 0, 8'd0, 0, 0);
        checks++; if ({res_valid, res_class, res_err} !== {1'b1, 2'd0, 1'b0}) begin
            fails++; $display("FAIL arp_result: got v%b c%0d e%b expected v1 c0 e0", res_valid, res_class, res_err); end
        checks++; if (cnt_frames !== 32'd2 || cnt_errs !== 32'd0) begin
            fails++; $display("FAIL arp_counters: got %0d/%0d expected 2/0", cnt_frames, cnt_errs); end
        res_ready = 1'b1;
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        res_ready = 1'b0;
        checks++; if (ipv4_seen - i0 !== 0) begin
            fails++; $display("FAIL arp_no_ipv4: got %0d ipv4_en cycles expected 0", ipv4_seen - i0); end
    endtask

    task automatic test_tcp_truncated;
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        cyc(1, 0, 1, 16'h0800, 0, 8'd0, 0, 0);
        cyc(1, 0, 0, 16'h0, 1, 8'd6, 0, 0);
        checks++; if (l4_en !== 1'b1) begin fails++; $display("FAIL tcp_l4_en: got %b expected 1", l4_en); end
        cyc(1, 1, 0, 16'h0, 0, 8'd0, 0, 0);
        checks++; if ({res_valid, res_class, res_err} !== {1'b1, 2'd3, 1'b1}) begin
            fails++; $display("FAIL tcp_result: got v%b c%0d e%b expected v1 c3 e1", res_valid, res_class, res_err); end
        checks++; if (cnt_frames !== 32'd3 || cnt_errs !== 32'd1) begin
            fails++; $display("FAIL tcp_counters: got %0d/%0d expected 3/1", cnt_frames, cnt_errs); end
        res_ready = 1'b1;
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        res_ready = 1'b0;
    endtask

    // Twelve-beat frame with no eth_done; result left pending on exit.
    task automatic test_timeout;
        for (int b = 1; b <= 12; b++) begin
            // Stray IPv4 done during ETH must be ignored.
            cyc(1, (b == 12), 0, 16'h0, (b == 3), 8'd17, 0, 0);
            if (b == 3) begin
                checks++; if ({eth_en, ipv4_en} !== 2'b10) begin
                    fails++; $display("FAIL stray_done: got %b expected 10", {eth_en, ipv4_en}); end
            end
            if (b == 7) begin
                checks++; if (eth_en !== 1'b1) begin fails++; $display("FAIL timeout_b7: got eth_en %b expected 1", eth_en); end
            end
            if (b == 8) begin
                checks++; if ({eth_en, ipv4_en, l4_en, res_valid} !== 4'b0) begin
                    fails++; $display("FAIL timeout_b8: got %b expected 0000", {eth_en, ipv4_en, l4_en, res_valid}); end
            end
        end
        checks++; if ({res_valid, res_class, res_err} !== {1'b1, 2'd0, 1'b1}) begin
            fails++; $display("FAIL timeout_result: got v%b c%0d e%b expected v1 c0 e1", res_valid, res_class, res_err); end
        checks++; if (cnt_frames !== 32'd4 || cnt_errs !== 32'd2) begin
            fails++; $display("FAIL timeout_counters: got %0d/%0d expected 4/2", cnt_frames, cnt_errs); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 3; c++) begin
            cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
            checks++; if ({s_tready, eth_en, res_valid} !== 3'b001) begin
                fails++; $display("FAIL stall_%0d: got %b expected 001", c, {s_tready, eth_en, res_valid}); end
        end
        res_ready = 1'b1;
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        res_ready = 1'b0;
        checks++; if ({res_valid, eth_en, s_tready} !== 3'b001) begin
            fails++; $display("FAIL accept_no_start: got %b expected 001", {res_valid, eth_en, s_tready}); end
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        checks++; if (eth_en !== 1'b1) begin fails++; $display("FAIL frame2_start: got eth_en %b expected 1", eth_en); end
        cyc(1, 1, 1, 16'h88cc, 0, 8'd0, 0, 0);
        checks++; if ({res_valid, res_class, res_err} !== {1'b1, 2'd0, 1'b0} || cnt_frames !== 32'd5) begin
            fails++; $display("FAIL frame2_result: got v%b c%0d e%b f%0d expected v1 c0 e0 f5", res_valid, res_class, res_err, cnt_frames); end
        res_ready = 1'b1;
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        cyc(1, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        cyc(1, 0, 1, 16'h0800, 0, 8'd0, 0, 0);
        checks++; if (ipv4_en !== 1'b1) begin fails++; $display("FAIL mid_ipv4_en: got %b expected 1", ipv4_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({eth_en, ipv4_en, l4_en, stage_flush, res_valid, res_err, s_tready} !== 7'b0000001) begin
            fails++; $display("FAIL mid_reset_ctrl: got %b expected 0000001", {eth_en, ipv4_en, l4_en, stage_flush, res_valid, res_err, s_tready}); end
        checks++; if (cnt_frames !== 32'd0 || cnt_errs !== 32'd0 || res_class !== 2'd0) begin
            fails++; $display("FAIL mid_reset_cnt: got %0d/%0d c%0d expected 0/0 c0", cnt_frames, cnt_errs, res_class); end
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        cyc(0, 0, 0, 16'h0, 0, 8'd0, 0, 0);
        checks++; if ({res_valid, stage_flush, ipv4_en, eth_en} !== 4'b0) begin
            fails++; $display("FAIL mid_reset_after: got %b expected 0000", {res_valid, stage_flush, ipv4_en, eth_en}); end
    endtask

    initial begin
        test_reset();
        test_udp();
        test_arp();
        test_tcp_truncated();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
